out_port_vc_arbiter: RTL and testbench
======================================

// Module: out_port_vc_arbiter
// PURPOSE
//  Per-output-port arbiter of the gold router. Shares one output port between NREQ input
//  ports, with a round-robin pointer per virtual channel (even/odd VC).
//  Owns the router polarity register: in polarity p it arbitrates internal VC p, while the
//  link serves VC ~p. Drives the crossbar select, input-buffer dequeue grants and the
//  output-buffer write strobe. One instance per output (N, S, E, W, NIC).
// PARAMETERS
//  NREQ  4  number of requesting input ports (>=2)
//  SELW  2  crossbar select width, $clog2(NREQ)
// PORTS
//  clk           in   1     router clock
//  reset         in   1     asynchronous, active-low (0 = reset)
//  req_even      in   NREQ  bit i: input i has a VC0 head flit routed to this output
//  req_odd       in   NREQ  bit i: input i has a VC1 head flit routed to this output
//  ob_full_even  in   1     output buffer VC0 full
//  ob_full_odd   in   1     output buffer VC1 full
//  polarity      out  1     current polarity; also feeds polarity_to_NIC
//  gnt           out  NREQ  one-hot registered grant; input i dequeues its VC gnt_vc head
//  gnt_vc        out  1     VC of the registered grant
//  xbar_sel      out  SELW  binary index of the granted input (valid when ob_wr=1)
//  ob_wr         out  1     write strobe into output buffer VC gnt_vc
// BEHAVIOUR
//  - Reset (async, reset=0): polarity=0, ptr_even=ptr_odd=0, gnt=0, gnt_vc=0, xbar_sel=0,
//    ob_wr=0. Any pending grant is dropped. No flit is written out of reset.
//  - polarity toggles on every rising clk edge after reset is released. The first cycle
//    after release has polarity=0.
//  - Arbitration is combinational in the cycle with polarity=p:
//    r = p ? req_odd : req_even; f = p ? ob_full_odd : ob_full_even; ptr = ptr_p.
//    If f=1 or r=0: no grant, and ptr_p holds.
//    Otherwise winner w = first set bit of r scanning ptr, ptr+1, .. NREQ-1, 0, .. (wraps).
//  - Registered at the edge: gnt<=onehot(w), xbar_sel<=w, gnt_vc<=p, ob_wr<=1, ptr_p<=(w+1)
//    mod NREQ (NREQ-1 wraps to 0). With no grant: gnt<=0, ob_wr<=0, and xbar_sel and
//    gnt_vc hold.
//  - Latency: request sampled in cycle t; grant/strobe visible in cycle t+1; flit written to
//    the output buffer at the end of t+1.
//  - The same VC is arbitrated again only at t+2. The dequeue and output-buffer update from
//    t+1 are therefore visible, so there is no double grant and no overflow without
//    lookahead.
//  - Only the pointer of the VC being arbitrated moves. The other VC's pointer is untouched.
//  - At most one gnt bit is set at any time. ob_wr == |gnt always.
//  - Requests may drop at any time. Only the value in the arbitration cycle matters.
//  - All NREQ requesting with the buffer never full: grants rotate 0,1,..,NREQ-1 per VC.
//    Worst-case wait is NREQ arbitrations of that VC (2*NREQ cycles).
// STRUCTURE
//  - router_pkg: VC_EVEN/VC_ODD localparams, NREQ default, function rr_pick(req, ptr)
//    returning {found, index}. The function is shared with the input-side arbiters.
//  - Sub-module rr_pick_core: combinational rotate / priority-encode / unrotate.
//    Instantiated once; its inputs are muxed by polarity.
//  - Top: polarity flop, two pointer registers, output register stage.
// TESTING
//  1 Reset: hold reset=0 for 4 cycles with req_even=4'hF.
//    -> gnt=0, ob_wr=0, polarity=0; first grant in cycle 1 after release.
//  2 Single requester: req_even=4'b0100 in a polarity-0 cycle.
//    -> next cycle gnt=4'b0100, xbar_sel=2, gnt_vc=0, ob_wr=1; ptr_even=3.
//  3 Rotation/wrap: req_odd=4'hF held, ob_full_odd=0.
//    -> odd grants 0,1,2,3,0 on successive polarity-1 cycles; never two bits set.
//  4 Backpressure: req_even=4'b0011, ob_full_even=1 for 3 even slots, then 0.
//    -> no even grant and ptr_even unchanged while full; then gnt=4'b0001.
//  5 VC independence: req_even=4'b1000, req_odd=4'b0001 together.
//    -> even slot grants 3 (gnt_vc=0), odd slot grants 0 (gnt_vc=1); each pointer moves once.
//  6 Reset mid-operation: assert reset while ob_wr=1.
//    -> gnt, ob_wr, polarity clear immediately (no clk edge needed); pointers = 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types and helpers.
// Used by output-port and input-side arbiters.
package router_pkg;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  localparam int NREQ_DEF = 4;
  localparam int SELW_DEF = $clog2(NREQ_DEF);

  // Round-robin pick: {found, index} of first set bit from ptr, wrapping.
  function automatic logic [SELW_DEF:0] rr_pick(
    input logic [NREQ_DEF-1:0] req,
    input logic [SELW_DEF-1:0] ptr
  );
    logic             found;
    logic [SELW_DEF-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ_DEF; i++) begin
      j = i + int'(ptr);
      if (j >= NREQ_DEF) j = j - NREQ_DEF;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SELW_DEF'(j);
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_pick_core.sv
// Round-robin pick: rotate by pointer,
// priority-encode, unrotate back to an input index.
module rr_pick_core #(
  parameter int NREQ = 4,
  parameter int SELW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  localparam logic [SELW:0] NW = (SELW+1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [SELW-1:0] off;
  logic [SELW:0]   sum;
  int              j;

  // Rotate so bit 0 is the pointer position, then find lowest set bit.
  always_comb begin
    rot = '0;
    off = '0;
    sum = '0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = i + int'(ptr);
      if (j >= NREQ) j = j - NREQ;
      rot[i] = req[j];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
    found = |rot;
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NW) sum = sum - NW;
    idx = sum[SELW-1:0];
  end

endmodule

// File: rtl/out_port_vc_arbiter.sv
// Output-port arbiter: polarity-alternating VC arbitration
// with one round-robin pointer per VC and registered grants.
module out_port_vc_arbiter
  import router_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int SELW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_even,
  input  logic [NREQ-1:0] req_odd,
  input  logic            ob_full_even,
  input  logic            ob_full_odd,
  output logic            polarity,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_vc,
  output logic [SELW-1:0] xbar_sel,
  output logic            ob_wr
);

  logic [SELW-1:0] ptr_even;
  logic [SELW-1:0] ptr_odd;
  logic [NREQ-1:0] req_cur;
  logic            full_cur;
  logic [SELW-1:0] ptr_cur;
  logic            found;
  logic [SELW-1:0] win;
  logic            take;
  logic [SELW-1:0] nxt;

  // Select the VC being arbitrated this cycle.
  always_comb begin
    req_cur  = (polarity == VC_ODD) ? req_odd : req_even;
    full_cur = (polarity == VC_ODD) ? ob_full_odd : ob_full_even;
    ptr_cur  = (polarity == VC_ODD) ? ptr_odd : ptr_even;
  end

  rr_pick_core #(
    .NREQ(NREQ),
    .SELW(SELW)
  ) u_pick (
    .req  (req_cur),
    .ptr  (ptr_cur),
    .found(found),
    .idx  (win)
  );

  // Grant only when a request exists and the target buffer has room.
  always_comb begin
    take = found & ~full_cur;
    nxt  = (win == SELW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  // Polarity, pointers and the registered grant stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity <= VC_EVEN;
      ptr_even <= '0;
      ptr_odd  <= '0;
      gnt      <= '0;
      gnt_vc   <= VC_EVEN;
      xbar_sel <= '0;
      ob_wr    <= 1'b0;
    end else begin
      polarity <= ~polarity;
      if (take) begin
        gnt      <= NREQ'(1) << win;
        xbar_sel <= win;
        gnt_vc   <= polarity;
        ob_wr    <= 1'b1;
        if (polarity == VC_ODD) ptr_odd <= nxt;
        else ptr_even <= nxt;
      end else begin
        gnt   <= '0;
        ob_wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_out_port_vc_arbiter.sv
// Directed-vector bench for out_port_vc_arbiter.
// Table rows are one cycle each, starting from polarity 0.
module tb_out_port_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_even;
  logic [3:0] req_odd;
  logic       ob_full_even;
  logic       ob_full_odd;
  logic       polarity;
  logic [3:0] gnt;
  logic       gnt_vc;
  logic [1:0] xbar_sel;
  logic       ob_wr;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] re;
    logic [3:0] ro;
    logic       fe;
    logic       fo;
    logic [3:0] g;
    logic       vc;
    logic [1:0] sel;
  } vec_t;

  vec_t vq[$];

  out_port_vc_arbiter #(.NREQ(4), .SELW(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_even    (req_even),
    .req_odd     (req_odd),
    .ob_full_even(ob_full_even),
    .ob_full_odd (ob_full_odd),
    .polarity    (polarity),
    .gnt         (gnt),
    .gnt_vc      (gnt_vc),
    .xbar_sel    (xbar_sel),
    .ob_wr       (ob_wr)
  );

  always #5 clk = ~clk;

  // Invariants checked on every falling edge.
  always @(negedge clk) begin
    checks++;
    if ($countones(gnt) > 1 || ob_wr != (|gnt)) begin
      errors++;
      $display("FAIL onehot: gnt=%b ob_wr=%b required onehot0 and ob_wr==|gnt",
               gnt, ob_wr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic [3:0] re, input logic [3:0] ro,
                     input logic fe, input logic fo, input logic [3:0] g,
                     input logic vc, input logic [1:0] sel);
    vq.push_back({re, ro, fe, fo, g, vc, sel});
  endtask

  task automatic check(input string name, input logic [3:0] g,
                       input logic vc, input logic [1:0] sel,
                       input logic wr, input logic pol);
    checks++;
    if (gnt !== g || gnt_vc !== vc || xbar_sel !== sel ||
        ob_wr !== wr || polarity !== pol) begin
      errors++;
      $display("FAIL %s: got gnt=%b vc=%b sel=%0d wr=%b pol=%b, required gnt=%b vc=%b sel=%0d wr=%b pol=%b",
               name, gnt, gnt_vc, xbar_sel, ob_wr, polarity,
               g, vc, sel, wr, pol);
    end
  endtask

  initial begin
    reset        = 1'b0;
    req_even     = 4'hF;
    req_odd      = 4'h0;
    ob_full_even = 1'b0;
    ob_full_odd  = 1'b0;

    // Held in reset with requests pending: nothing granted.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reset_hold", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    end

    // First cycle after release is polarity 0 and grants input 0.
    reset = 1'b1;
    tick();
    check("first_grant", 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1);

    // Async reset clears without a clock edge.
    reset = 1'b0;
    #1;
    check("async_clear1", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    req_even = 4'b0000;
    reset    = 1'b1;

    // Single requester, then odd rotation with wrap.
    row(4'b0100, 4'h0, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd2);
    row(4'b0100, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3);
    row(4'b0000, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);
    // Even backpressure for three even slots, ptr_even stays 3.
    row(4'b0011, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0);
    row(4'b0011, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0);
    row(4'b0011, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0);
    row(4'b0011, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0);
    row(4'b0011, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0);
    row(4'b0011, 4'h0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0);
    row(4'b0011, 4'h0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0);
    // VC independence: ptr_odd=1, ptr_even=1.
    row(4'b1000, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);
    row(4'b1000, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd3);
    row(4'hF, 4'hF, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1);
    row(4'hF, 4'hF, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0);
    // Odd backpressure, then resume from ptr_odd=2.
    row(4'h0, 4'hF, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    row(4'h0, 4'hF, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0);
    row(4'h0, 4'hF, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2);
    // Pointer skips idle inputs.
    row(4'b1001, 4'h0, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd3);
    row(4'h0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0);

    foreach (vq[i]) begin
      req_even     = vq[i].re;
      req_odd      = vq[i].ro;
      ob_full_even = vq[i].fe;
      ob_full_odd  = vq[i].fo;
      tick();
      check($sformatf("row%0d", i), vq[i].g, vq[i].vc, vq[i].sel,
            |vq[i].g, (i % 2) == 0);
    end

    // Reset while ob_wr=1; pointers must return to 0 (ptr_odd was 1).
    reset = 1'b0;
    #1;
    check("async_clear2", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    req_even     = 4'h0;
    req_odd      = 4'b0011;
    ob_full_even = 1'b0;
    ob_full_odd  = 1'b0;
    reset        = 1'b1;
    tick();
    check("post_reset_even", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    check("post_reset_odd", 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
